lvl_state_ctrl: RTL and testbench

- Sequencer for the level-state array of the Sat Engine (per-level dcd_bin plus has_bkt, daisy-chained lvl_state tree).
- Forwards decisions into the array.
- Runs the find-backtrack-level search and applies the backtrack.
- Streams level states in (bin load) and out (bin update) one level per beat, so the engine never drives the array directly.

---
 rtl/lvl_state_ctrl.sv | 158 +++++++++++++++
 tb/tb_lvl_state_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvl_state_ctrl.sv
// Sequencer for the Sat Engine level-state array: forwards decisions, runs the
// backtrack-level search/apply, and streams level states in and out one level per beat.
module lvl_state_ctrl #(
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_LVL_STATES = 11,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_BIN_ID     = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 dcd_valid_i,
    input  logic [WIDTH_BIN_ID-1:0]              dcd_bin_i,
    input  logic [WIDTH_LVL-1:0]                 dcd_lvl_i,
    output logic                                 dcd_ready_o,
    input  logic                                 bkt_req_i,
    input  logic [WIDTH_LVL-1:0]                 max_lvl_i,
    output logic                                 bkt_done_o,
    output logic                                 bkt_found_o,
    output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
    output logic [WIDTH_BIN_ID-1:0]              bkt_bin_o,
    input  logic                                 load_start_i,
    input  logic                                 load_valid_i,
    input  logic [WIDTH_LVL_STATES-1:0]          load_data_i,
    output logic                                 load_ready_o,
    output logic                                 load_done_o,
    input  logic                                 store_start_i,
    output logic                                 store_valid_o,
    output logic [WIDTH_LVL_STATES-1:0]          store_data_o,
    input  logic                                 store_ready_i,
    output logic                                 store_done_o,
    output logic                                 busy_o,
    output logic                                 arr_valid_from_decision_o,
    output logic [WIDTH_BIN_ID-1:0]              arr_cur_bin_num_o,
    output logic [WIDTH_LVL-1:0]                 arr_cur_lvl_o,
    output logic [1:0]                           arr_findflag_left_o,
    input  logic [1:0]                           arr_findflag_left_i,
    output logic [WIDTH_LVL-1:0]                 arr_max_lvl_o,
    input  logic [WIDTH_BIN_ID-1:0]              arr_bkt_bin_i,
    input  logic [WIDTH_LVL-1:0]                 arr_bkt_lvl_i,
    output logic                                 arr_apply_bkt_o,
    output logic [NUM_LVLS-1:0]                  arr_wr_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] arr_lvl_states_o,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] arr_lvl_states_i
);

    localparam int IDX_W = (NUM_LVLS > 1) ? $clog2(NUM_LVLS) : 1;

    typedef enum logic [2:0] {IDLE, SEARCH, EVAL, APPLY, LOAD, STORE} state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0]                                idx;
    logic [NUM_LVLS-1:0][WIDTH_LVL_STATES-1:0]       shadow;
    logic                                            dcd_pulse_q;
    logic [WIDTH_BIN_ID-1:0]                         cur_bin_q;
    logic [WIDTH_LVL-1:0]                            cur_lvl_q;
    logic [WIDTH_LVL-1:0]                            max_lvl_q;
    logic                                            found_q;
    logic [WIDTH_LVL-1:0]                            bkt_lvl_q;
    logic [WIDTH_BIN_ID-1:0]                         bkt_bin_q;
    logic                                            load_done_q;
    logic                                            store_done_q;

    logic is_idle, take_bkt, take_store, take_load, take_dcd;
    logic load_hs, store_hs, last_idx, eval_found;

    // Fixed request priority in IDLE: backtrack, store, load, decision.
    assign is_idle    = (state == IDLE);
    assign take_bkt   = is_idle & bkt_req_i;
    assign take_store = is_idle & ~bkt_req_i & store_start_i;
    assign take_load  = is_idle & ~bkt_req_i & ~store_start_i & load_start_i;
    assign take_dcd   = is_idle & ~bkt_req_i & ~store_start_i & ~load_start_i & dcd_valid_i;
    assign load_hs    = (state == LOAD) & load_valid_i;
    assign store_hs   = (state == STORE) & store_ready_i;
    assign last_idx   = (idx == IDX_W'(NUM_LVLS - 1));
    assign eval_found = (arr_findflag_left_i != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take_bkt)        state_nxt = SEARCH;
                else if (take_store) state_nxt = STORE;
                else if (take_load)  state_nxt = LOAD;
            end
            SEARCH:  state_nxt = EVAL;
            EVAL:    state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            LOAD:    if (load_hs && last_idx)  state_nxt = IDLE;
            STORE:   if (store_hs && last_idx) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx          <= '0;
            shadow       <= '0;
            dcd_pulse_q  <= 1'b0;
            cur_bin_q    <= '0;
            cur_lvl_q    <= '0;
            max_lvl_q    <= '0;
            found_q      <= 1'b0;
            bkt_lvl_q    <= '0;
            bkt_bin_q    <= '0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
        end else begin
            dcd_pulse_q  <= take_dcd;
            load_done_q  <= load_hs & last_idx;
            store_done_q <= store_hs & last_idx;
            if (take_dcd) begin
                cur_bin_q <= dcd_bin_i;
                cur_lvl_q <= dcd_lvl_i;
            end
            if (take_bkt) max_lvl_q <= max_lvl_i;
            // Search results are captured once; a missing level reports zeros.
            if (state == EVAL) begin
                found_q   <= eval_found;
                bkt_lvl_q <= eval_found ? arr_bkt_lvl_i : '0;
                bkt_bin_q <= eval_found ? arr_bkt_bin_i : '0;
            end
            if (take_store) shadow <= arr_lvl_states_i;
            if (take_load || take_store)  idx <= '0;
            else if (load_hs || store_hs) idx <= idx + 1'b1;
        end
    end

    always_comb begin
        arr_wr_states_o = '0;
        if (load_hs) arr_wr_states_o[idx] = 1'b1;
    end

    assign dcd_ready_o               = is_idle & rst;
    assign busy_o                    = ~is_idle;
    assign arr_valid_from_decision_o = dcd_pulse_q;
    assign arr_cur_bin_num_o         = cur_bin_q;
    assign arr_cur_lvl_o             = cur_lvl_q;
    assign arr_findflag_left_o       = 2'b00;
    assign arr_max_lvl_o             = max_lvl_q;
    assign arr_apply_bkt_o           = (state == APPLY) & found_q;
    assign bkt_done_o                = (state == APPLY);
    assign bkt_found_o               = found_q;
    assign bkt_lvl_o                 = bkt_lvl_q;
    assign bkt_bin_o                 = bkt_bin_q;
    assign load_ready_o              = (state == LOAD);
    assign load_done_o               = load_done_q;
    assign arr_lvl_states_o          = (state == LOAD) ? {NUM_LVLS{load_data_i}} : '0;
    assign store_valid_o             = (state == STORE);
    assign store_data_o              = (state == STORE) ? shadow[idx] : '0;
    assign store_done_o              = store_done_q;

endmodule

// File: tb/tb_lvl_state_ctrl.sv
// Randomized self-checking bench for lvl_state_ctrl with a small behavioural
// level-state array and a per-level expected-contents model.
module tb_lvl_state_ctrl;

    localparam int N  = 8;
    localparam int W  = 11;
    localparam int WL = 16;
    localparam int WB = 10;

    logic            clk;
    logic            rst;
    logic            dcd_valid_i;
    logic [WB-1:0]   dcd_bin_i;
    logic [WL-1:0]   dcd_lvl_i;
    logic            dcd_ready_o;
    logic            bkt_req_i;
    logic [WL-1:0]   max_lvl_i;
    logic            bkt_done_o;
    logic            bkt_found_o;
    logic [WL-1:0]   bkt_lvl_o;
    logic [WB-1:0]   bkt_bin_o;
    logic            load_start_i;
    logic            load_valid_i;
    logic [W-1:0]    load_data_i;
    logic            load_ready_o;
    logic            load_done_o;
    logic            store_start_i;
    logic            store_valid_o;
    logic [W-1:0]    store_data_o;
    logic            store_ready_i;
    logic            store_done_o;
    logic            busy_o;
    logic            arr_valid_from_decision_o;
    logic [WB-1:0]   arr_cur_bin_num_o;
    logic [WL-1:0]   arr_cur_lvl_o;
    logic [1:0]      arr_findflag_left_o;
    logic [1:0]      arr_findflag_left_i;
    logic [WL-1:0]   arr_max_lvl_o;
    logic [WB-1:0]   arr_bkt_bin_i;
    logic [WL-1:0]   arr_bkt_lvl_i;
    logic            arr_apply_bkt_o;
    logic [N-1:0]    arr_wr_states_o;
    logic [W*N-1:0]  arr_lvl_states_o;
    logic [W*N-1:0]  arr_lvl_states_i;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mem [N];
    logic [W-1:0] scramble;
    logic [W-1:0] model_mem [N];

    lvl_state_ctrl dut (
        .clk(clk), .rst(rst),
        .dcd_valid_i(dcd_valid_i), .dcd_bin_i(dcd_bin_i), .dcd_lvl_i(dcd_lvl_i),
        .dcd_ready_o(dcd_ready_o),
        .bkt_req_i(bkt_req_i), .max_lvl_i(max_lvl_i), .bkt_done_o(bkt_done_o),
        .bkt_found_o(bkt_found_o), .bkt_lvl_o(bkt_lvl_o), .bkt_bin_o(bkt_bin_o),
        .load_start_i(load_start_i), .load_valid_i(load_valid_i), .load_data_i(load_data_i),
        .load_ready_o(load_ready_o), .load_done_o(load_done_o),
        .store_start_i(store_start_i), .store_valid_o(store_valid_o),
        .store_data_o(store_data_o), .store_ready_i(store_ready_i), .store_done_o(store_done_o),
        .busy_o(busy_o),
        .arr_valid_from_decision_o(arr_valid_from_decision_o),
        .arr_cur_bin_num_o(arr_cur_bin_num_o), .arr_cur_lvl_o(arr_cur_lvl_o),
        .arr_findflag_left_o(arr_findflag_left_o), .arr_findflag_left_i(arr_findflag_left_i),
        .arr_max_lvl_o(arr_max_lvl_o), .arr_bkt_bin_i(arr_bkt_bin_i), .arr_bkt_lvl_i(arr_bkt_lvl_i),
        .arr_apply_bkt_o(arr_apply_bkt_o), .arr_wr_states_o(arr_wr_states_o),
        .arr_lvl_states_o(arr_lvl_states_o), .arr_lvl_states_i(arr_lvl_states_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural array: each level slot takes its slice when its write strobe is set.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++)
            if (arr_wr_states_o[k]) mem[k] <= arr_lvl_states_o[k*W +: W];
    end

    always_comb begin
        arr_lvl_states_i = '0;
        for (int k = 0; k < N; k++) arr_lvl_states_i[k*W +: W] = mem[k] ^ scramble;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        dcd_valid_i = 0; bkt_req_i = 0; load_start_i = 0; load_valid_i = 0;
        store_start_i = 0; store_ready_i = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        clear_inputs();
        dcd_bin_i = '0; dcd_lvl_i = '0; max_lvl_i = '0; load_data_i = '0;
        arr_findflag_left_i = 2'b00; arr_bkt_bin_i = '0; arr_bkt_lvl_i = '0;
        scramble = '0;
        #3;
        total++; if (dcd_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_dcd_ready: got %b want 0", dcd_ready_o); end
        total++; if (busy_o !== 1'b0 || bkt_done_o !== 1'b0 || store_valid_o !== 1'b0 || arr_wr_states_o !== '0)
            begin bad++; $display("[TB] FAIL reset_outputs: busy=%b done=%b sv=%b wr=%h want all 0", busy_o, bkt_done_o, store_valid_o, arr_wr_states_o); end
        cyc(); cyc();
        rst = 1;
        #1;
        total++; if (dcd_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_release_ready: got %b want 1", dcd_ready_o); end
        total++; if (arr_findflag_left_o !== 2'b00) begin bad++; $display("[TB] FAIL findflag_const: got %b want 00", arr_findflag_left_o); end
        // Start a load, write levels 0..2, then reset while level 3 is being offered.
        load_start_i = 1;
        cyc();
        load_start_i = 0;
        for (int b = 0; b < 3; b++) begin
            load_valid_i = 1; load_data_i = W'($urandom);
            cyc();
        end
        load_valid_i = 1; load_data_i = W'($urandom);
        #1;
        total++; if (arr_wr_states_o !== 8'h08) begin bad++; $display("[TB] FAIL midload_idx3: got %h want 08", arr_wr_states_o); end
        rst = 0;
        #1;
        total++; if (busy_o !== 1'b0 || arr_wr_states_o !== '0 || load_ready_o !== 1'b0)
            begin bad++; $display("[TB] FAIL midload_reset: busy=%b wr=%h rdy=%b want 0", busy_o, arr_wr_states_o, load_ready_o); end
        cyc();
        rst = 1;
        load_valid_i = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (load_done_o !== 1'b0 || busy_o !== 1'b0)
                begin bad++; $display("[TB] FAIL after_reset_quiet: done=%b busy=%b want 0", load_done_o, busy_o); end
            cyc();
        end
    endtask

    task automatic test_decision(input int n);
        for (int i = 0; i < n; i++) begin
            logic [WB-1:0] b;
            logic [WL-1:0] l;
            b = (i == 0) ? WB'(5) : WB'($urandom);
            l = (i == 0) ? WL'(2) : WL'($urandom);
            dcd_valid_i = 1; dcd_bin_i = b; dcd_lvl_i = l;
            #1;
            total++; if (dcd_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL dcd_ready: got %b want 1", dcd_ready_o); end
            cyc();
            dcd_valid_i = 0; dcd_bin_i = WB'($urandom); dcd_lvl_i = WL'($urandom);
            #1;
            total++; if (arr_valid_from_decision_o !== 1'b1 || arr_cur_bin_num_o !== b || arr_cur_lvl_o !== l)
                begin bad++; $display("[TB] FAIL dcd_pulse: v=%b bin=%0d lvl=%0d want 1 %0d %0d", arr_valid_from_decision_o, arr_cur_bin_num_o, arr_cur_lvl_o, b, l); end
            cyc();
            #1;
            total++; if (arr_valid_from_decision_o !== 1'b0 || busy_o !== 1'b0)
                begin bad++; $display("[TB] FAIL dcd_pulse_len: v=%b busy=%b want 0 0", arr_valid_from_decision_o, busy_o); end
        end
    endtask

    task automatic test_backtrack(input logic [1:0] flag, input logic [WL-1:0] lvl,
                                  input logic [WB-1:0] bin, input logic [WL-1:0] maxl);
        logic          exp_found;
        logic [WL-1:0] exp_lvl;
        logic [WB-1:0] exp_bin;
        exp_found = (flag != 2'b00);
        exp_lvl   = exp_found ? lvl : '0;
        exp_bin   = exp_found ? bin : '0;
        arr_findflag_left_i = flag; arr_bkt_lvl_i = lvl; arr_bkt_bin_i = bin;
        bkt_req_i = 1; max_lvl_i = maxl;
        #1;
        cyc();
        bkt_req_i = 0; max_lvl_i = ~maxl;
        for (int c = 1; c <= 2; c++) begin
            #1;
            total++; if (bkt_done_o !== 1'b0 || busy_o !== 1'b1 || dcd_ready_o !== 1'b0 || arr_max_lvl_o !== maxl || arr_apply_bkt_o !== 1'b0)
                begin bad++; $display("[TB] FAIL bkt_wait%0d: done=%b busy=%b rdy=%b max=%0d apply=%b want max %0d", c, bkt_done_o, busy_o, dcd_ready_o, arr_max_lvl_o, arr_apply_bkt_o, maxl); end
            cyc();
        end
        #1;
        total++; if (bkt_done_o !== 1'b1 || bkt_found_o !== exp_found || bkt_lvl_o !== exp_lvl || bkt_bin_o !== exp_bin || arr_apply_bkt_o !== exp_found)
            begin bad++; $display("[TB] FAIL bkt_result: done=%b found=%b lvl=%0d bin=%0d apply=%b want 1 %b %0d %0d %b", bkt_done_o, bkt_found_o, bkt_lvl_o, bkt_bin_o, arr_apply_bkt_o, exp_found, exp_lvl, exp_bin, exp_found); end
        arr_findflag_left_i = ~flag; arr_bkt_lvl_i = WL'($urandom); arr_bkt_bin_i = WB'($urandom);
        cyc();
        #1;
        total++; if (bkt_done_o !== 1'b0 || arr_apply_bkt_o !== 1'b0 || busy_o !== 1'b0 || bkt_found_o !== exp_found || bkt_lvl_o !== exp_lvl || bkt_bin_o !== exp_bin)
            begin bad++; $display("[TB] FAIL bkt_hold: done=%b apply=%b busy=%b found=%b lvl=%0d bin=%0d", bkt_done_o, arr_apply_bkt_o, busy_o, bkt_found_o, bkt_lvl_o, bkt_bin_o); end
    endtask

    task automatic test_load(input logic directed);
        logic [W-1:0] data [N];
        int beat;
        int budget;
        for (int k = 0; k < N; k++) data[k] = directed ? W'(12'h101 + k) : W'($urandom);
        load_start_i = 1;
        cyc();
        load_start_i = 0;
        beat = 0; budget = 0;
        while (beat < N && budget < 200) begin
            logic v;
            logic [N-1:0] e;
            v = ($urandom_range(0, 2) != 0);
            e = '0;
            if (v) e[beat] = 1'b1;
            load_valid_i = v; load_data_i = v ? data[beat] : W'($urandom);
            #1;
            total++; if (load_ready_o !== 1'b1 || load_done_o !== 1'b0 || arr_wr_states_o !== e)
                begin bad++; $display("[TB] FAIL load_beat%0d: rdy=%b done=%b wr=%h want 1 0 %h", beat, load_ready_o, load_done_o, arr_wr_states_o, e); end
            if (v) begin
                total++; if (arr_lvl_states_o[beat*W +: W] !== data[beat])
                    begin bad++; $display("[TB] FAIL load_slice%0d: got %h want %h", beat, arr_lvl_states_o[beat*W +: W], data[beat]); end
            end
            cyc();
            if (v) beat++;
            budget++;
        end
        if (beat < N) begin total++; bad++; $display("[TB] FAIL load_timeout: beats %0d want %0d", beat, N); end
        load_valid_i = 0;
        #1;
        total++; if (load_done_o !== 1'b1 || busy_o !== 1'b0)
            begin bad++; $display("[TB] FAIL load_done: done=%b busy=%b want 1 0", load_done_o, busy_o); end
        cyc();
        #1;
        total++; if (load_done_o !== 1'b0) begin bad++; $display("[TB] FAIL load_done_len: got %b want 0", load_done_o); end
        for (int k = 0; k < N; k++) model_mem[k] = data[k];
    endtask

    task automatic run_store_beats(input logic random_ready);
        int beat;
        int budget;
        beat = 0; budget = 0;
        while (beat < N && budget < 200) begin
            logic r;
            r = random_ready ? logic'($urandom_range(0, 1)) : 1'b1;
            store_ready_i = r;
            #1;
            total++; if (store_valid_o !== 1'b1 || store_done_o !== 1'b0 || store_data_o !== model_mem[beat])
                begin bad++; $display("[TB] FAIL store_beat%0d: v=%b done=%b data=%h want 1 0 %h", beat, store_valid_o, store_done_o, store_data_o, model_mem[beat]); end
            // Disturb the array after entry; the readout must come from the snapshot.
            scramble = W'($urandom) | W'(1);
            cyc();
            if (r) beat++;
            budget++;
        end
        if (beat < N) begin total++; bad++; $display("[TB] FAIL store_timeout: beats %0d want %0d", beat, N); end
        store_ready_i = 0; scramble = '0;
        #1;
        total++; if (store_done_o !== 1'b1 || busy_o !== 1'b0)
            begin bad++; $display("[TB] FAIL store_done: done=%b busy=%b want 1 0", store_done_o, busy_o); end
        cyc();
        #1;
        total++; if (store_done_o !== 1'b0) begin bad++; $display("[TB] FAIL store_done_len: got %b want 0", store_done_o); end
    endtask

    task automatic test_store();
        store_start_i = 1;
        cyc();
        store_start_i = 0;
        run_store_beats(1'b1);
    endtask

    task automatic test_contention();
        logic [1:0] flag;
        flag = 2'($urandom_range(1, 3));
        arr_findflag_left_i = flag; arr_bkt_lvl_i = WL'(9); arr_bkt_bin_i = WB'(33);
        bkt_req_i = 1; load_start_i = 1; dcd_valid_i = 1; max_lvl_i = WL'(12);
        dcd_bin_i = WB'($urandom); dcd_lvl_i = WL'($urandom);
        cyc();
        clear_inputs();
        for (int c = 1; c <= 3; c++) begin
            #1;
            total++; if (arr_valid_from_decision_o !== 1'b0 || load_ready_o !== 1'b0 || busy_o !== 1'b1 || dcd_ready_o !== 1'b0 || bkt_done_o !== logic'(c == 3))
                begin bad++; $display("[TB] FAIL contention_bkt%0d: dcd=%b lrdy=%b busy=%b rdy=%b done=%b", c, arr_valid_from_decision_o, load_ready_o, busy_o, dcd_ready_o, bkt_done_o); end
            cyc();
        end
        #1;
        total++; if (busy_o !== 1'b0 || dcd_ready_o !== 1'b1 || load_done_o !== 1'b0 || bkt_found_o !== 1'b1 || bkt_lvl_o !== WL'(9))
            begin bad++; $display("[TB] FAIL contention_end: busy=%b rdy=%b ldone=%b found=%b lvl=%0d", busy_o, dcd_ready_o, load_done_o, bkt_found_o, bkt_lvl_o); end
        // Store beats load and decision on the same cycle.
        store_start_i = 1; load_start_i = 1; dcd_valid_i = 1;
        cyc();
        clear_inputs();
        #1;
        total++; if (arr_valid_from_decision_o !== 1'b0 || load_ready_o !== 1'b0 || store_valid_o !== 1'b1)
            begin bad++; $display("[TB] FAIL contention_store: dcd=%b lrdy=%b sv=%b want 0 0 1", arr_valid_from_decision_o, load_ready_o, store_valid_o); end
        run_store_beats(1'b0);
    endtask

    initial begin
        test_reset();
        test_decision(6);
        test_backtrack(2'b01, WL'(3), WB'(7), WL'(6));
        test_backtrack(2'b00, WL'(4), WB'(9), WL'(0));
        for (int i = 0; i < 6; i++) begin
            logic [1:0] f;
            f = ($urandom_range(0, 1) != 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            test_backtrack(f, WL'($urandom), WB'($urandom), WL'($urandom));
        end
        test_load(1'b1);
        test_store();
        test_load(1'b0);
        test_store();
        test_contention();
        test_decision(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
